// File: rtl/stopwatch_pkg.sv
// Shared constants for the millisecond stopwatch/timer.
// Field widths and per-field maximum values for the minute, second and
// millisecond fields. The hour field width is a parameter of the top, so
// the full time record is declared there, built from these widths.
package stopwatch_pkg;
  localparam int MS_W    = 10;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  // Minute/second/millisecond part of a time value; the top prepends the hour.
  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [MS_W-1:0]  ms;
  } mss_t;

  localparam mss_t MSS_ZERO = '0;
endpackage

// File: rtl/stopwatch_timer_ms_tick.sv
// ms_tick_gen: prescaler that produces a one-cycle tick every CLK_DIV
// cycles while run is high.
//   clk_i, reset_i : clock, synchronous active-high reset
//   run            : count enable (counter holds while low)
//   restart        : force the count back to 0 (wins over run)
//   tick           : high in the cycle the count equals CLK_DIV-1
module ms_tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run,
  input  logic restart,
  output logic tick
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || restart)  cnt_q <= '0;
    else if (run)            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tick = run && (cnt_q == LAST);
endmodule

// File: rtl/stopwatch_timer_ms.sv
// stopwatch_timer_ms: hh:mm:ss.mmm up/down counter with preset load,
// lap capture, end-of-count (done_o) and wrap (wrap_o) pulses.
//   inputs : clk_i, reset_i (sync, active high), start_i/stop_i/clear_i/
//            load_i/lap_i command pulses, mode_i (1 = count down),
//            *_set_i preset fields (saturated on load)
//   outputs: current time, lap time + lap_valid_o, running_o, done_o,
//            wrap_o; all registered.
module stopwatch_timer_ms
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV  = 100000,
  parameter int HOUR_W   = 5,
  parameter int HOUR_MAX = 23
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              mode_i,
  input  logic              lap_i,
  input  logic [HOUR_W-1:0] hour_set_i,
  input  logic [MIN_W-1:0]  min_set_i,
  input  logic [SEC_W-1:0]  sec_set_i,
  input  logic [MS_W-1:0]   ms_set_i,
  output logic [HOUR_W-1:0] hour_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [SEC_W-1:0]  sec_o,
  output logic [MS_W-1:0]   ms_o,
  output logic [HOUR_W-1:0] lap_hour_o,
  output logic [MIN_W-1:0]  lap_min_o,
  output logic [SEC_W-1:0]  lap_sec_o,
  output logic [MS_W-1:0]   lap_ms_o,
  output logic              lap_valid_o,
  output logic              running_o,
  output logic              done_o,
  output logic              wrap_o
);
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    mss_t              f;
  } time_t;

  localparam time_t             TIME_ZERO = '0;
  localparam logic [HOUR_W-1:0] HMAX = HOUR_W'(HOUR_MAX);
  localparam logic [MIN_W-1:0]  MNM  = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0]  SM   = SEC_W'(SEC_MAX);
  localparam logic [MS_W-1:0]   MSM  = MS_W'(MS_MAX);

  time_t cur_q, lap_q, set_sat, t_up, t_dn;
  logic  running_q, lap_valid_q, done_q, wrap_q;
  logic  tick, at_zero, at_max, start_go, restart;

  assign at_zero = (cur_q == TIME_ZERO);
  assign at_max  = (cur_q.hour == HMAX) && (cur_q.f.min == MNM) &&
                   (cur_q.f.sec == SM) && (cur_q.f.ms == MSM);
  // A down-count start from zero would end immediately; it is dropped.
  assign start_go = start_i && !(mode_i && at_zero);
  assign restart  = clear_i || load_i || (!stop_i && start_go);

  ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .run     (running_q),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    set_sat.hour  = (hour_set_i > HMAX) ? HMAX : hour_set_i;
    set_sat.f.min = (min_set_i  > MNM)  ? MNM  : min_set_i;
    set_sat.f.sec = (sec_set_i  > SM)   ? SM   : sec_set_i;
    set_sat.f.ms  = (ms_set_i   > MSM)  ? MSM  : ms_set_i;
  end

  // Carry chain: each field rolls only when all lower fields roll.
  always_comb begin
    t_up = cur_q;
    if (cur_q.f.ms != MSM)         t_up.f.ms  = cur_q.f.ms + 1'b1;
    else begin
      t_up.f.ms = '0;
      if (cur_q.f.sec != SM)       t_up.f.sec = cur_q.f.sec + 1'b1;
      else begin
        t_up.f.sec = '0;
        if (cur_q.f.min != MNM)    t_up.f.min = cur_q.f.min + 1'b1;
        else begin
          t_up.f.min = '0;
          t_up.hour  = (cur_q.hour == HMAX) ? '0 : cur_q.hour + 1'b1;
        end
      end
    end
  end

  // Borrow chain; only used when cur_q is non-zero, so hour never underflows.
  always_comb begin
    t_dn = cur_q;
    if (cur_q.f.ms != '0)          t_dn.f.ms  = cur_q.f.ms - 1'b1;
    else begin
      t_dn.f.ms = MSM;
      if (cur_q.f.sec != '0)       t_dn.f.sec = cur_q.f.sec - 1'b1;
      else begin
        t_dn.f.sec = SM;
        if (cur_q.f.min != '0)     t_dn.f.min = cur_q.f.min - 1'b1;
        else begin
          t_dn.f.min = MNM;
          t_dn.hour  = cur_q.hour - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_q       <= TIME_ZERO;
      lap_q       <= TIME_ZERO;
      running_q   <= 1'b0;
      lap_valid_q <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      // Lap sees the value before any command on this edge.
      lap_valid_q <= lap_i;
      if (lap_i) lap_q <= cur_q;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear_i) begin
        cur_q     <= TIME_ZERO;
        running_q <= 1'b0;
      end else if (load_i) begin
        cur_q     <= set_sat;
        running_q <= 1'b0;
      end else if (stop_i) begin
        running_q <= 1'b0;
      end else if (start_i) begin
        if (start_go) running_q <= 1'b1;
      end else if (tick) begin
        if (!mode_i) begin
          cur_q  <= t_up;
          wrap_q <= at_max;
        end else if (at_zero || (t_dn == TIME_ZERO)) begin
          cur_q     <= TIME_ZERO;
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          cur_q <= t_dn;
        end
      end
    end
  end

  assign hour_o      = cur_q.hour;
  assign min_o       = cur_q.f.min;
  assign sec_o       = cur_q.f.sec;
  assign ms_o        = cur_q.f.ms;
  assign lap_hour_o  = lap_q.hour;
  assign lap_min_o   = lap_q.f.min;
  assign lap_sec_o   = lap_q.f.sec;
  assign lap_ms_o    = lap_q.f.ms;
  assign lap_valid_o = lap_valid_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;
endmodule

// File: tb/tb_stopwatch_timer_ms.sv
// Bench for stopwatch_timer_ms with CLK_DIV=4, HOUR_MAX=1. The reference
// model keeps time as a single millisecond total and derives fields by
// division; directed scenarios compare against literal expected times.
module tb_stopwatch_timer_ms;
  localparam int CLK_DIV = 4, HOUR_W = 5, HOUR_MAX = 1;
  localparam int PERIOD  = (HOUR_MAX + 1) * 3600000;

  logic clk = 0, rst = 1, st = 0, sp = 0, cl = 0, ld = 0, md = 0, lp = 0;
  logic [4:0] hs = 0;
  logic [5:0] mns = 0, ss = 0;
  logic [9:0] mss = 0;
  logic [4:0] hour_o, lap_hour_o;
  logic [5:0] min_o, sec_o, lap_min_o, lap_sec_o;
  logic [9:0] ms_o, lap_ms_o;
  logic lap_valid_o, running_o, done_o, wrap_o;

  int n_checks = 0, n_fail = 0;

  // reference model state
  int m_t = 0, m_lap = 0, m_pre = 0;
  bit m_run = 0, m_lapv = 0, m_done = 0, m_wrap = 0;

  logic [57:0] obs_v, exp_v;
  logic [26:0] obs_t;

  stopwatch_timer_ms #(.CLK_DIV(CLK_DIV), .HOUR_W(HOUR_W), .HOUR_MAX(HOUR_MAX)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(st), .stop_i(sp), .clear_i(cl),
    .load_i(ld), .mode_i(md), .lap_i(lp), .hour_set_i(hs), .min_set_i(mns),
    .sec_set_i(ss), .ms_set_i(mss), .hour_o(hour_o), .min_o(min_o),
    .sec_o(sec_o), .ms_o(ms_o), .lap_hour_o(lap_hour_o), .lap_min_o(lap_min_o),
    .lap_sec_o(lap_sec_o), .lap_ms_o(lap_ms_o), .lap_valid_o(lap_valid_o),
    .running_o(running_o), .done_o(done_o), .wrap_o(wrap_o));

  always #5 clk = ~clk;

  function automatic logic [26:0] pack_t(int t);
    return {5'(t / 3600000), 6'((t / 60000) % 60), 6'((t / 1000) % 60), 10'(t % 1000)};
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge of the reference behaviour, applied to the current inputs.
  task automatic model_edge();
    bit tk;
    if (rst) begin
      m_t = 0; m_lap = 0; m_pre = 0; m_run = 0; m_lapv = 0; m_done = 0; m_wrap = 0;
      return;
    end
    m_lapv = lp;
    if (lp) m_lap = m_t;
    m_done = 0; m_wrap = 0;
    tk = m_run && (m_pre == CLK_DIV - 1);
    if (m_run) m_pre = (m_pre + 1) % CLK_DIV;
    if (cl) begin
      m_t = 0; m_run = 0; m_pre = 0;
    end else if (ld) begin
      m_t = min_i(hs, HOUR_MAX) * 3600000 + min_i(mns, 59) * 60000 +
            min_i(ss, 59) * 1000 + min_i(mss, 999);
      m_run = 0; m_pre = 0;
    end else if (sp) begin
      m_run = 0;
    end else if (st) begin
      if (!(md && m_t == 0)) begin m_run = 1; m_pre = 0; end
    end else if (tk) begin
      if (!md) begin
        if (m_t == PERIOD - 1) begin m_t = 0; m_wrap = 1; end
        else m_t = m_t + 1;
      end else begin
        if (m_t > 0) m_t = m_t - 1;
        if (m_t == 0) begin m_run = 0; m_done = 1; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; st = 0; sp = 0; cl = 0; ld = 0; lp = 0;
    obs_t = {hour_o, min_o, sec_o, ms_o};
    obs_v = {obs_t, running_o, done_o, wrap_o, lap_valid_o,
             lap_hour_o, lap_min_o, lap_sec_o, lap_ms_o};
    exp_v = {pack_t(m_t), m_run, m_done, m_wrap, m_lapv, pack_t(m_lap)};
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(int h, int m, int s, int ms, bit mode);
    hs = 5'(h); mns = 6'(m); ss = 6'(s); mss = 10'(ms); md = mode; ld = 1;
    step();
  endtask

  task automatic test_reset();
    rst = 1; step(); rst = 1; step();
    n_checks++;
    if (obs_v !== 58'd0) begin
      n_fail++; $display("FAIL reset_initial: got %h want 0", obs_v);
    end
    md = 0; st = 1; step(); steps(50);
    n_checks++;
    if (running_o !== 1'b1 || ms_o !== 10'd12) begin
      n_fail++; $display("FAIL reset_precount: got run=%b ms=%0d want run=1 ms=12", running_o, ms_o);
    end
    rst = 1; step();
    n_checks++;
    if (obs_v !== 58'd0) begin
      n_fail++; $display("FAIL reset_midcount: got %h want 0", obs_v);
    end
  endtask

  task automatic test_up_carry();
    do_load(0, 0, 59, 999, 0);
    st = 1; step(); steps(CLK_DIV);
    n_checks++;
    if (obs_t !== {5'd0, 6'd1, 6'd0, 10'd0} || running_o !== 1'b1) begin
      n_fail++; $display("FAIL up_carry: got %h run=%b want 0:01:00.000 run=1", obs_t, running_o);
    end
    do_load(1, 59, 59, 999, 0);
    st = 1; step(); steps(CLK_DIV);
    n_checks++;
    if (obs_t !== 27'd0 || wrap_o !== 1'b1) begin
      n_fail++; $display("FAIL up_wrap: got %h wrap=%b want 0 wrap=1", obs_t, wrap_o);
    end
    step();
    n_checks++;
    if (wrap_o !== 1'b0 || obs_t !== 27'd0 || running_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pulse: got wrap=%b t=%h run=%b want wrap=0 t=0 run=1", wrap_o, obs_t, running_o);
    end
  endtask

  task automatic test_down_end();
    do_load(0, 0, 0, 2, 1);
    st = 1; step(); steps(CLK_DIV);
    n_checks++;
    if (obs_t !== 27'd1 || running_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL down_1ms: got t=%h run=%b done=%b want t=1 run=1 done=0", obs_t, running_o, done_o);
    end
    steps(CLK_DIV);
    n_checks++;
    if (obs_t !== 27'd0 || running_o !== 1'b0 || done_o !== 1'b1) begin
      n_fail++; $display("FAIL down_end: got t=%h run=%b done=%b want t=0 run=0 done=1", obs_t, running_o, done_o);
    end
    step();
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: got %b want 0", done_o);
    end
    st = 1; step(); steps(CLK_DIV + 1);
    n_checks++;
    if (running_o !== 1'b0 || done_o !== 1'b0 || obs_t !== 27'd0) begin
      n_fail++; $display("FAIL start_at_zero: got run=%b done=%b t=%h want 0 0 0", running_o, done_o, obs_t);
    end
  endtask

  task automatic test_borrow();
    do_load(0, 1, 0, 0, 1);
    st = 1; step(); steps(CLK_DIV);
    n_checks++;
    if (obs_t !== {5'd0, 6'd0, 6'd59, 10'd999}) begin
      n_fail++; $display("FAIL borrow: got %h want 0:00:59.999", obs_t);
    end
  endtask

  task automatic test_lap_clear();
    do_load(0, 0, 0, 1, 0);
    st = 1; step(); steps(4 * CLK_DIV);
    lp = 1; cl = 1; step();
    n_checks++;
    if ({lap_hour_o, lap_min_o, lap_sec_o, lap_ms_o} !== 27'd5 || lap_valid_o !== 1'b1 ||
        obs_t !== 27'd0 || running_o !== 1'b0) begin
      n_fail++; $display("FAIL lap_clear: got lap=%0d lv=%b t=%h run=%b want lap=5 lv=1 t=0 run=0",
                         lap_ms_o, lap_valid_o, obs_t, running_o);
    end
    step();
    n_checks++;
    if (lap_valid_o !== 1'b0 || lap_ms_o !== 10'd5) begin
      n_fail++; $display("FAIL lap_pulse: got lv=%b lap_ms=%0d want lv=0 lap_ms=5", lap_valid_o, lap_ms_o);
    end
  endtask

  task automatic test_collision_sat();
    md = 0; st = 1; sp = 1; step();
    n_checks++;
    if (running_o !== 1'b0) begin
      n_fail++; $display("FAIL start_stop: got run=%b want 0", running_o);
    end
    do_load(31, 63, 63, 1023, 0);
    n_checks++;
    if (obs_t !== {5'd1, 6'd59, 6'd59, 10'd999} || running_o !== 1'b0) begin
      n_fail++; $display("FAIL saturate: got %h run=%b want 1:59:59.999 run=0", obs_t, running_o);
    end
  endtask

  task automatic test_random();
    int r, e = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      rst = (r < 3);
      cl  = (r >= 3 && r < 20);
      ld  = (r >= 20 && r < 45);
      sp  = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 9) == 0);
      lp  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) md = ~md;
      case ($urandom_range(0, 3))
        0: begin hs = 5'(HOUR_MAX); mns = 59; ss = 59; mss = 10'($urandom_range(995, 999)); end
        1: begin hs = 0; mns = 0; ss = 0; mss = 10'($urandom_range(0, 4)); end
        2: begin hs = 5'($urandom); mns = 6'($urandom); ss = 6'($urandom); mss = 10'($urandom); end
        default: begin hs = 0; mns = 6'($urandom_range(0, 1)); ss = 6'($urandom_range(0, 1)); mss = 10'($urandom_range(0, 1)); end
      endcase
      step();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        if (e < 10) $display("FAIL random cycle %0d: got %h want %h", i, obs_v, exp_v);
        e++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_down_end();
    test_borrow();
    test_lap_clear();
    test_collision_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
